// File: rtl/wb_uart_rx_pkg.sv
// Shared definitions for the Wishbone UART receiver: register offsets,
// STATUS bit positions, receiver FSM states and divisor helper.
package wb_uart_rx_pkg;

  // Register select values for addr[3:2]; also used by the transmit block.
  localparam logic [1:0] REG_RXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  localparam int unsigned ST_NEMPTY    = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVR       = 2;
  localparam int unsigned ST_FERR      = 3;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned RXD_VALID    = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // A programmed divisor of 0 behaves as 1.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for the UART receiver. Reset clears the pointers
// and count only; storage is left untouched.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot, so a push alongside it is accepted even when full.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_uart_rx.sv
// Wishbone-slave 8N1 UART receiver with programmable bit period, RX FIFO,
// sticky overrun/framing flags and a level interrupt while data waits.
module wb_uart_rx
  import wb_uart_rx_pkg::*;
#(
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV   = 16'd867
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  input  logic                     uart_rx_i,
  output logic                     rx_irq_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic                     meta_q, rxs_q;
  rx_state_e                state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [2:0]               bitn_q, bitn_d;
  logic [7:0]               shreg_q, shreg_d;
  logic [15:0]              div_q, div_d, div_eff;
  logic                     ovr_q, ovr_d;
  logic                     ferr_q, ferr_d;
  logic                     ack_q, ack_d;
  logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                     irq_q;

  logic                     push_req, ferr_set;
  logic                     req, pop, clr_ovr, clr_ferr, div_we;
  logic [1:0]               reg_sel;
  logic [WB_DATA_WIDTH-1:0] rd_val;
  logic [7:0]               fifo_rdata;
  logic                     fifo_full, fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic                     unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0],
                         wb_data_i[WB_DATA_WIDTH-1:16]};

  assign wb_ack_o  = ack_q;
  assign wb_data_o = rdata_q;
  assign rx_irq_o  = irq_q;
  assign div_eff   = eff_div(div_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= uart_rx_i;
      rxs_q  <= meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitn_d   = bitn_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          state_d = RX_START;
          cnt_d   = div_eff >> 1;
        end
      end
      RX_START: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!rxs_q) begin
          state_d = RX_DATA;
          cnt_d   = div_eff;
          bitn_d  = 3'd0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shreg_d = {rxs_q, shreg_q[7:1]};
          cnt_d   = div_eff;
          if (bitn_q == 3'd7) state_d = RX_STOP;
          else                bitn_d  = bitn_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          state_d  = RX_IDLE;
          push_req = rxs_q;
          ferr_set = !rxs_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push_req),
    .data_i (shreg_d),
    .pop_i  (pop),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Side effects are committed on the edge that raises ack, so they land
  // exactly once per acknowledged access.
  always_comb begin
    req      = wb_cyc_i && wb_stb_i && !ack_q;
    reg_sel  = wb_addr_i[3:2];
    rd_val   = '0;
    unique case (reg_sel)
      REG_RXDATA: begin
        if (!fifo_empty) begin
          rd_val[RXD_VALID] = 1'b1;
          rd_val[7:0]       = fifo_rdata;
        end
      end
      REG_STATUS: begin
        rd_val[ST_NEMPTY]            = !fifo_empty;
        rd_val[ST_FULL]              = fifo_full;
        rd_val[ST_OVR]               = ovr_q;
        rd_val[ST_FERR]              = ferr_q;
        rd_val[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
      end
      REG_DIVISOR: rd_val[15:0] = div_q;
      default:     rd_val = '0;
    endcase
    pop      = req && !wb_we_i && (reg_sel == REG_RXDATA) && !fifo_empty;
    clr_ovr  = req && wb_we_i && (reg_sel == REG_STATUS) && wb_data_i[ST_OVR];
    clr_ferr = req && wb_we_i && (reg_sel == REG_STATUS) && wb_data_i[ST_FERR];
    div_we   = req && wb_we_i && (reg_sel == REG_DIVISOR);
    ack_d    = req;
    rdata_d  = (req && !wb_we_i) ? rd_val : '0;
    div_d    = div_we ? wb_data_i[15:0] : div_q;
    ovr_d    = (push_req && fifo_full && !pop) || (ovr_q && !clr_ovr);
    ferr_d   = ferr_set || (ferr_q && !clr_ferr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      div_q   <= DEFAULT_DIV;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      div_q   <= div_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      irq_q   <= !fifo_empty;
    end
  end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed self-checking bench for wb_uart_rx: frame reception, glitch
// rejection, framing error, overrun, full push/pop collision and reset.
module tb_wb_uart_rx;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic        ack;
  logic [31:0] rdata;
  logic        rx;
  logic        irq;

  int unsigned n_cmp;
  int unsigned n_err;

  wb_uart_rx #(
    .WB_DATA_WIDTH(32),
    .WB_ADDR_WIDTH(32),
    .FIFO_DEPTH   (8),
    .DEFAULT_DIV  (16'd867)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wb_addr_i(addr),
    .wb_data_i(wdata),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_ack_o (ack),
    .wb_data_o(rdata),
    .uart_rx_i(rx),
    .rx_irq_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_access(input logic [3:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] q);
    bit got;
    @(posedge clk); #1;
    addr = {28'd0, a}; we = w; wdata = d; cyc = 1'b1; stb = 1'b1;
    got = 0; q = '0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (ack) begin
        got = 1;
        q = rdata;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_access(a, 1'b0, 32'd0, q);
    chk(tag, q, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_access(a, 1'b1, d, q);
  endtask

  // Start bit is driven just after the first posedge; each bit lasts bc clocks.
  task automatic send_byte(input logic [7:0] b, input logic stopv, input int unsigned bc);
    @(posedge clk); #1 rx = 1'b0;
    repeat (bc) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bc) @(posedge clk);
      #1;
    end
    rx = stopv;
    repeat (bc) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_irq(input string tag, input int unsigned bound);
    bit seen;
    seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (irq) seen = 1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  int unsigned lat;

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; addr = '0; wdata = '0; sel = 4'hF; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rdchk("rst_status", 4'h4, 32'h0000_0000);
    rdchk("rst_div", 4'h8, 32'h0000_0363);
    rdchk("reg_c", 4'hC, 32'h0000_0000);
    wr(4'h8, 32'hFFFF_0003);
    rdchk("div_3", 4'h8, 32'h0000_0003);

    // 1: clean 0xA5 frame; irq rises 42 clk after the start edge with this pipeline.
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1, 4);
      begin
        @(posedge clk);
        while (lat < 80) begin
          @(negedge clk);
          lat++;
          if (irq) break;
        end
      end
    join
    chk("irq_latency", {31'd0, (lat >= 34 && lat <= 46)}, 32'd1);
    rdchk("a5_status", 4'h4, 32'h0000_0101);
    rdchk("a5_rxdata", 4'h0, 32'h0000_01A5);
    rdchk("a5_status_after", 4'h4, 32'h0000_0000);
    @(negedge clk);
    chk("a5_irq_low", {31'd0, irq}, 32'd0);
    rdchk("empty_read", 4'h0, 32'h0000_0000);

    // 2: single-cycle low glitch on idle line.
    @(posedge clk); #1 rx = 1'b0;
    @(posedge clk); #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    rdchk("glitch_status", 4'h4, 32'h0000_0000);

    // 3: framing error, then software clear.
    send_byte(8'h3C, 1'b0, 4);
    repeat (8) @(posedge clk);
    rdchk("ferr_status", 4'h4, 32'h0000_0008);
    wr(4'h4, 32'h0000_0008);
    rdchk("ferr_cleared", 4'h4, 32'h0000_0000);

    // 4: overrun on the ninth byte.
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1, 4);
    repeat (4) @(posedge clk);
    rdchk("ovr_status", 4'h4, 32'h0000_0807);
    for (int i = 0; i < 8; i++) rdchk("ovr_drain", 4'h0, 32'h100 | i);
    rdchk("ovr_drained", 4'h0, 32'h0000_0000);
    rdchk("ovr_sticky", 4'h4, 32'h0000_0004);
    wr(4'h4, 32'h0000_0004);
    rdchk("ovr_cleared", 4'h4, 32'h0000_0000);

    // 5: fill, then pop on the same edge that pushes 0x18.
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1, 4);
    repeat (4) @(posedge clk);
    rdchk("full_status", 4'h4, 32'h0000_0803);
    fork
      send_byte(8'h18, 1'b1, 4);
      begin
        repeat (40) @(posedge clk);
        rdchk("coll_rxdata", 4'h0, 32'h0000_0110);
      end
    join
    repeat (2) @(posedge clk);
    rdchk("coll_status", 4'h4, 32'h0000_0803);
    for (int i = 1; i < 9; i++) rdchk("coll_drain", 4'h0, 32'h100 | (32'h10 + i));
    rdchk("coll_empty", 4'h4, 32'h0000_0000);

    // 6: reset during data bit 4 with a byte already queued.
    send_byte(8'h77, 1'b1, 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    fork
      send_byte(8'hF0, 1'b1, 4);
      begin
        repeat (22) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    @(negedge clk);
    chk("mid_rst_ack", {31'd0, ack}, 32'd0);
    chk("mid_rst_data", rdata, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    rdchk("mid_rst_status", 4'h4, 32'h0000_0000);
    rdchk("mid_rst_div", 4'h8, 32'h0000_0363);
    send_byte(8'h5A, 1'b1, 868);
    wait_irq("div867_irq", 200);
    rdchk("div867_rxdata", 4'h0, 32'h0000_015A);
    rdchk("div867_status", 4'h4, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
